// File: rtl/io_pkg.sv
// ============================================================================
// Module      : io_pkg
// Description : Shared definitions for the I/O request arbiter: FSM state
//               encoding, default data width and channel index constants.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package io_pkg;

    // Grant FSM encoding
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRESENT = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    // Default byte width of every channel and of INPR/OUTR
    localparam int DW_DEFAULT = 8;

    // Fixed channel assignment
    localparam int CH_KBD = 0;
    localparam int CH_SPI = 1;

endpackage : io_pkg

`default_nettype wire

// File: rtl/io_req_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector. Returns the first pending
//               channel at or after the pointer, wrapping modulo N_CH.
// Ports       : i_pending  pending vector, one bit per channel
//               i_ptr      round-robin start index (always < N_CH)
//               o_grant    selected channel index
//               o_any      at least one channel pending
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N_CH = 2
) (
    input  logic [N_CH-1:0] i_pending,
    input  logic [1:0]      i_ptr,
    output logic [1:0]      o_grant,
    output logic            o_any
);

    logic [3:0] w_pend4;
    logic [2:0] w_idx;

    // Zero-pad to four entries so a 2-bit index is always in range
    assign w_pend4 = 4'(i_pending);
    assign o_any   = |i_pending;

    // Walk offsets from the farthest down to zero so the closest pending
    // channel to the pointer is the last (winning) assignment.
    always_comb begin
        o_grant = 2'd0;
        w_idx   = 3'd0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            w_idx = {1'b0, i_ptr} + 3'(k);
            if (w_idx >= 3'(N_CH)) begin
                w_idx = w_idx - 3'(N_CH);
            end
            if (w_pend4[w_idx[1:0]]) begin
                o_grant = w_idx[1:0];
            end
        end
    end

endmodule : rr_pick

`default_nettype wire

// File: rtl/io_req_arbiter.sv
// ============================================================================
// Module      : io_req_arbiter
// Description : Shares the single INPR/FGI input register and the interrupt
//               line between N_CH byte-wide requesters (ch0 keyboard,
//               ch1 SPI rx). Each channel has its own holding register;
//               pending channels are granted round-robin and the granted
//               byte is held until the CPU executes INP. Also owns FGO, the
//               display latch and IEN gating of the interrupt request.
// Ports       : clk, rst           clock, synchronous active-high reset
//               ch_req/ch_data     per-channel request level and byte
//               ch_ovf             sticky per-channel overrun flags
//               inpr/fgi/src       byte, flag and source index for the CPU
//               inp_ack            CPU executed INP
//               outr_in/out_stb    CPU OUT data and strobe
//               fgo/disp           output flag and display latch
//               ion/iof            CPU interrupt enable / disable pulses
//               irq                registered interrupt request
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module io_req_arbiter
    import io_pkg::*;
#(
    parameter int N_CH = 2,              // 2..4
    parameter int DW   = DW_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CH-1:0]    ch_req,
    input  logic [N_CH*DW-1:0] ch_data,
    output logic [N_CH-1:0]    ch_ovf,
    output logic [DW-1:0]      inpr,
    output logic               fgi,
    output logic [1:0]         src,
    input  logic               inp_ack,
    input  logic [DW-1:0]      outr_in,
    input  logic               out_stb,
    output logic               fgo,
    output logic [DW-1:0]      disp,
    input  logic               ion,
    input  logic               iof,
    output logic               irq
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [N_CH-1:0] r_req_q;
    logic [N_CH-1:0] r_pending;
    logic [N_CH-1:0] r_ovf;
    logic [DW-1:0]   r_hold [N_CH];
    logic [DW-1:0]   r_inpr;
    logic [1:0]      r_src;
    logic            r_fgi;
    logic [1:0]      r_ptr;
    logic [1:0]      r_state;
    logic            r_fgo;
    logic [DW-1:0]   r_disp;
    logic            r_ien;
    logic            r_irq;

    logic [N_CH-1:0] w_edge;
    logic [1:0]      w_grant;
    logic            w_any;
    logic [1:0]      w_state_next;
    logic            w_load;
    logic            w_release;
    logic [DW-1:0]   w_sel_byte;
    logic [1:0]      w_ptr_next;

    assign w_edge = ch_req & ~r_req_q;

    // ------------------------------------------------------------------
    // Round-robin selection
    // ------------------------------------------------------------------
    rr_pick #(
        .N_CH (N_CH)
    ) u_rr_pick (
        .i_pending (r_pending),
        .i_ptr     (r_ptr),
        .o_grant   (w_grant),
        .o_any     (w_any)
    );

    always_comb begin
        w_sel_byte = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_grant == 2'(i)) begin
                w_sel_byte = r_hold[i];
            end
        end
    end

    assign w_ptr_next = (r_src == 2'(N_CH - 1)) ? 2'd0 : r_src + 2'd1;

    // ------------------------------------------------------------------
    // Grant FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_any)   w_state_next = S_PRESENT;
            S_PRESENT: if (inp_ack) w_state_next = S_RELEASE;
            S_RELEASE: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_load    = (r_state == S_IDLE) && w_any;
        w_release = (r_state == S_PRESENT) && inp_ack;
    end

    // ------------------------------------------------------------------
    // Per-channel edge capture
    // ------------------------------------------------------------------
    // A new edge on the channel being acknowledged in this same cycle is a
    // fresh capture, not an overrun: the old byte is being consumed now.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_q   <= '0;
            r_pending <= '0;
            r_ovf     <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            r_req_q <= ch_req;
            for (int i = 0; i < N_CH; i++) begin
                if (w_edge[i]) begin
                    if (r_pending[i] && !(w_release && (r_src == 2'(i)))) begin
                        r_ovf[i] <= 1'b1;
                    end else begin
                        r_hold[i]    <= ch_data[i*DW +: DW];
                        r_pending[i] <= 1'b1;
                    end
                end else if (w_release && (r_src == 2'(i))) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // CPU-facing input register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inpr <= '0;
            r_src  <= 2'd0;
            r_fgi  <= 1'b0;
            r_ptr  <= 2'd0;
        end else if (w_load) begin
            r_inpr <= w_sel_byte;
            r_src  <= w_grant;
            r_fgi  <= 1'b1;
        end else if (w_release) begin
            r_fgi  <= 1'b0;
            r_ptr  <= w_ptr_next;
        end
    end

    // ------------------------------------------------------------------
    // Output path: display is always ready one cycle after OUT
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fgo  <= 1'b1;
            r_disp <= '0;
        end else begin
            r_fgo <= ~out_stb;
            if (out_stb) begin
                r_disp <= outr_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Interrupt enable and registered request (iof has priority)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ien <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_ien & (r_fgi | r_fgo);
            if (iof) begin
                r_ien <= 1'b0;
            end else if (ion) begin
                r_ien <= 1'b1;
            end
        end
    end

    assign ch_ovf = r_ovf;
    assign inpr   = r_inpr;
    assign fgi    = r_fgi;
    assign src    = r_src;
    assign fgo    = r_fgo;
    assign disp   = r_disp;
    assign irq    = r_irq;

endmodule : io_req_arbiter

`default_nettype wire

// File: tb/tb_io_req_arbiter.sv
// ============================================================================
// Module      : tb_io_req_arbiter
// Description : Self-checking bench for io_req_arbiter (N_CH=2, DW=8).
//               A per-cycle vector table followed by directed sequences for
//               reset mid-grant and simultaneous-event corner cases.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_io_req_arbiter;
    import io_pkg::*;

    localparam int C_NCH = 2;
    localparam int C_DW  = 8;

    logic              clk;
    logic              rst;
    logic [1:0]        ch_req;
    logic [15:0]       ch_data;
    logic [1:0]        ch_ovf;
    logic [7:0]        inpr;
    logic              fgi;
    logic [1:0]        src;
    logic              inp_ack;
    logic [7:0]        outr_in;
    logic              out_stb;
    logic              fgo;
    logic [7:0]        disp;
    logic              ion;
    logic              iof;
    logic              irq;

    int n_checks = 0;
    int n_fail   = 0;

    io_req_arbiter #(
        .N_CH (C_NCH),
        .DW   (C_DW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ch_req  (ch_req),
        .ch_data (ch_data),
        .ch_ovf  (ch_ovf),
        .inpr    (inpr),
        .fgi     (fgi),
        .src     (src),
        .inp_ack (inp_ack),
        .outr_in (outr_in),
        .out_stb (out_stb),
        .fgo     (fgo),
        .disp    (disp),
        .ion     (ion),
        .iof     (iof),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [15:0] data;
        logic        ack;
        logic [7:0]  outr;
        logic        ostb;
        logic        ion;
        logic        iof;
        logic        e_fgi;
        logic [7:0]  e_inpr;
        logic [1:0]  e_src;
        logic        e_fgo;
        logic [7:0]  e_disp;
        logic        e_irq;
        logic [1:0]  e_ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [1:0] rq, input logic [15:0] d,
                       input logic a, input logic [7:0] o, input logic os,
                       input logic en, input logic di,
                       input logic efgi, input logic [7:0] einpr, input logic [1:0] esrc,
                       input logic efgo, input logic [7:0] edisp, input logic eirq,
                       input logic [1:0] eovf);
        vec_t v;
        v.rst = r; v.req = rq; v.data = d; v.ack = a; v.outr = o; v.ostb = os;
        v.ion = en; v.iof = di;
        v.e_fgi = efgi; v.e_inpr = einpr; v.e_src = esrc; v.e_fgo = efgo;
        v.e_disp = edisp; v.e_irq = eirq; v.e_ovf = eovf;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int tag, input logic [15:0] act,
                       input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %h expected %h", nm, tag, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] rq, input logic [15:0] d,
                         input logic a);
        rst = r; ch_req = rq; ch_data = d; inp_ack = a;
        outr_in = 8'h00; out_stb = 1'b0; ion = 1'b0; iof = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 2'b00, 16'h0000, 1'b0);

        //   rst req    data      ack outr  ostb ion iof | fgi inpr   src fgo disp  irq ovf
        add(1, 2'b00, 16'h0000, 0, 8'h00, 0, 0, 0,   0, 8'h00, 0, 1, 8'h00, 0, 2'b00); // 0 reset
        add(0, 2'b01, 16'h0077, 0, 8'h00, 0, 0, 0,   0, 8'h00, 0, 1, 8'h00, 0, 2'b00); // 1 ch0 edge
        add(0, 2'b01, 16'h0077, 0, 8'h00, 0, 0, 0,   1, 8'h77, 0, 1, 8'h00, 0, 2'b00); // 2 granted
        add(0, 2'b01, 16'h0077, 0, 8'h00, 0, 0, 0,   1, 8'h77, 0, 1, 8'h00, 0, 2'b00); // 3 held
        add(0, 2'b01, 16'h0077, 1, 8'h00, 0, 0, 0,   0, 8'h77, 0, 1, 8'h00, 0, 2'b00); // 4 ack
        add(0, 2'b01, 16'h0077, 0, 8'h00, 0, 0, 0,   0, 8'h77, 0, 1, 8'h00, 0, 2'b00); // 5 release
        add(0, 2'b01, 16'h0077, 0, 8'h00, 0, 0, 0,   0, 8'h77, 0, 1, 8'h00, 0, 2'b00); // 6 stays low
        add(0, 2'b00, 16'h0077, 0, 8'h00, 0, 0, 0,   0, 8'h77, 0, 1, 8'h00, 0, 2'b00); // 7
        add(1, 2'b00, 16'h0000, 0, 8'h00, 0, 0, 0,   0, 8'h00, 0, 1, 8'h00, 0, 2'b00); // 8 reset
        add(0, 2'b11, 16'h6677, 0, 8'h00, 0, 0, 0,   0, 8'h00, 0, 1, 8'h00, 0, 2'b00); // 9 both edge
        add(0, 2'b11, 16'h6677, 0, 8'h00, 0, 0, 0,   1, 8'h77, 0, 1, 8'h00, 0, 2'b00); // 10 ch0 first
        add(0, 2'b11, 16'h6677, 1, 8'h00, 0, 0, 0,   0, 8'h77, 0, 1, 8'h00, 0, 2'b00); // 11 ack
        add(0, 2'b11, 16'h6677, 0, 8'h00, 0, 0, 0,   0, 8'h77, 0, 1, 8'h00, 0, 2'b00); // 12
        add(0, 2'b11, 16'h6677, 0, 8'h00, 0, 0, 0,   1, 8'h66, 1, 1, 8'h00, 0, 2'b00); // 13 ch1
        add(0, 2'b11, 16'h6677, 1, 8'h00, 0, 0, 0,   0, 8'h66, 1, 1, 8'h00, 0, 2'b00); // 14 ack
        add(0, 2'b00, 16'h6677, 0, 8'h00, 0, 0, 0,   0, 8'h66, 1, 1, 8'h00, 0, 2'b00); // 15
        add(0, 2'b11, 16'h2211, 0, 8'h00, 0, 0, 0,   0, 8'h66, 1, 1, 8'h00, 0, 2'b00); // 16 both edge
        add(0, 2'b11, 16'h2211, 0, 8'h00, 0, 0, 0,   1, 8'h11, 0, 1, 8'h00, 0, 2'b00); // 17 ch0 again
        add(0, 2'b11, 16'h2211, 1, 8'h00, 0, 0, 0,   0, 8'h11, 0, 1, 8'h00, 0, 2'b00); // 18
        add(0, 2'b11, 16'h2211, 0, 8'h00, 0, 0, 0,   0, 8'h11, 0, 1, 8'h00, 0, 2'b00); // 19
        add(0, 2'b11, 16'h2211, 0, 8'h00, 0, 0, 0,   1, 8'h22, 1, 1, 8'h00, 0, 2'b00); // 20
        add(0, 2'b11, 16'h2211, 1, 8'h00, 0, 0, 0,   0, 8'h22, 1, 1, 8'h00, 0, 2'b00); // 21
        add(0, 2'b00, 16'h2211, 0, 8'h00, 0, 0, 0,   0, 8'h22, 1, 1, 8'h00, 0, 2'b00); // 22
        add(0, 2'b01, 16'h0077, 0, 8'h00, 0, 0, 0,   0, 8'h22, 1, 1, 8'h00, 0, 2'b00); // 23 ch0 77
        add(0, 2'b00, 16'h0066, 0, 8'h00, 0, 0, 0,   1, 8'h77, 0, 1, 8'h00, 0, 2'b00); // 24
        add(0, 2'b01, 16'h0066, 0, 8'h00, 0, 0, 0,   1, 8'h77, 0, 1, 8'h00, 0, 2'b01); // 25 overrun
        add(0, 2'b01, 16'h0066, 1, 8'h00, 0, 0, 0,   0, 8'h77, 0, 1, 8'h00, 0, 2'b01); // 26 ack
        add(0, 2'b01, 16'h0066, 0, 8'h00, 0, 0, 0,   0, 8'h77, 0, 1, 8'h00, 0, 2'b01); // 27
        add(0, 2'b01, 16'h0066, 0, 8'h00, 0, 0, 0,   0, 8'h77, 0, 1, 8'h00, 0, 2'b01); // 28 no regrant
        add(0, 2'b00, 16'h0066, 0, 8'h00, 0, 1, 0,   0, 8'h77, 0, 1, 8'h00, 0, 2'b01); // 29 ion
        add(0, 2'b00, 16'h0066, 0, 8'h00, 0, 0, 0,   0, 8'h77, 0, 1, 8'h00, 1, 2'b01); // 30
        add(0, 2'b10, 16'h5A66, 0, 8'h00, 0, 0, 0,   0, 8'h77, 0, 1, 8'h00, 1, 2'b01); // 31 ch1 edge
        add(0, 2'b10, 16'h5A66, 0, 8'h00, 0, 0, 0,   1, 8'h5A, 1, 1, 8'h00, 1, 2'b01); // 32
        add(0, 2'b10, 16'h5A66, 0, 8'h00, 0, 0, 0,   1, 8'h5A, 1, 1, 8'h00, 1, 2'b01); // 33
        add(0, 2'b10, 16'h5A66, 0, 8'h00, 0, 1, 1,   1, 8'h5A, 1, 1, 8'h00, 1, 2'b01); // 34 ion+iof
        add(0, 2'b10, 16'h5A66, 0, 8'h00, 0, 0, 0,   1, 8'h5A, 1, 1, 8'h00, 0, 2'b01); // 35
        add(0, 2'b10, 16'h5A66, 1, 8'h00, 0, 0, 0,   0, 8'h5A, 1, 1, 8'h00, 0, 2'b01); // 36
        add(0, 2'b00, 16'h5A66, 0, 8'h3C, 1, 0, 0,   0, 8'h5A, 1, 0, 8'h3C, 0, 2'b01); // 37 OUT
        add(0, 2'b00, 16'h5A66, 0, 8'h00, 0, 0, 0,   0, 8'h5A, 1, 1, 8'h3C, 0, 2'b01); // 38
        add(0, 2'b00, 16'h5A66, 0, 8'hA5, 1, 0, 0,   0, 8'h5A, 1, 0, 8'hA5, 0, 2'b01); // 39
        add(0, 2'b00, 16'h5A66, 0, 8'hC3, 1, 0, 0,   0, 8'h5A, 1, 0, 8'hC3, 0, 2'b01); // 40 fgo=0
        add(0, 2'b00, 16'h5A66, 0, 8'h00, 0, 0, 0,   0, 8'h5A, 1, 1, 8'hC3, 0, 2'b01); // 41

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; ch_req = tbl[i].req; ch_data = tbl[i].data;
            inp_ack = tbl[i].ack; outr_in = tbl[i].outr; out_stb = tbl[i].ostb;
            ion = tbl[i].ion; iof = tbl[i].iof;
            step();
            chk("fgi",    i, 16'(fgi),    16'(tbl[i].e_fgi));
            chk("inpr",   i, 16'(inpr),   16'(tbl[i].e_inpr));
            chk("src",    i, 16'(src),    16'(tbl[i].e_src));
            chk("fgo",    i, 16'(fgo),    16'(tbl[i].e_fgo));
            chk("disp",   i, 16'(disp),   16'(tbl[i].e_disp));
            chk("irq",    i, 16'(irq),    16'(tbl[i].e_irq));
            chk("ch_ovf", i, 16'(ch_ovf), 16'(tbl[i].e_ovf));
        end

        // Reset while presenting: byte discarded, held request re-captured
        drive(1'b0, 2'b01, 16'h0077, 1'b0); step();
        chk("rstA_fgi0", 100, 16'(fgi), 16'h0);
        drive(1'b0, 2'b01, 16'h0077, 1'b0); step();
        chk("rstA_fgi1", 101, 16'(fgi), 16'h1);
        chk("rstA_inpr", 101, 16'(inpr), 16'h0077);
        drive(1'b1, 2'b01, 16'h0077, 1'b0); step();
        chk("rstA_fgi",  102, 16'(fgi), 16'h0);
        chk("rstA_inpr0",102, 16'(inpr), 16'h0000);
        chk("rstA_fgo",  102, 16'(fgo), 16'h1);
        chk("rstA_ovf",  102, 16'(ch_ovf), 16'h0);
        chk("rstA_disp", 102, 16'(disp), 16'h0);
        drive(1'b0, 2'b01, 16'h0077, 1'b0); step();
        chk("rstA_rel",  103, 16'(fgi), 16'h0);
        drive(1'b0, 2'b01, 16'h0077, 1'b0); step();
        chk("rstA_recap",104, 16'(fgi), 16'h1);
        chk("rstA_rinpr",104, 16'(inpr), 16'h0077);
        chk("rstA_rsrc", 104, 16'(src), 16'(CH_KBD));

        // Edge on the granted channel in the ack cycle is a fresh capture
        drive(1'b0, 2'b00, 16'h0077, 1'b0); step();
        chk("simB_hold", 110, 16'(fgi), 16'h1);
        drive(1'b0, 2'b01, 16'h0099, 1'b1); step();
        chk("simB_fgi",  111, 16'(fgi), 16'h0);
        chk("simB_ovf",  111, 16'(ch_ovf), 16'h0);
        drive(1'b0, 2'b01, 16'h0099, 1'b0); step();
        chk("simB_rel",  112, 16'(fgi), 16'h0);
        drive(1'b0, 2'b01, 16'h0099, 1'b0); step();
        chk("simB_fgi1", 113, 16'(fgi), 16'h1);
        chk("simB_inpr", 113, 16'(inpr), 16'h0099);
        chk("simB_src",  113, 16'(src), 16'(CH_KBD));

        // Edge on a channel in the cycle IDLE selects it counts as overrun
        drive(1'b0, 2'b10, 16'h4499, 1'b1); step();
        chk("simC_fgi",  120, 16'(fgi), 16'h0);
        drive(1'b0, 2'b00, 16'h4499, 1'b0); step();
        drive(1'b0, 2'b10, 16'h5599, 1'b0); step();
        chk("simC_fgi1", 122, 16'(fgi), 16'h1);
        chk("simC_inpr", 122, 16'(inpr), 16'h0044);
        chk("simC_src",  122, 16'(src), 16'(CH_SPI));
        chk("simC_ovf",  122, 16'(ch_ovf), 16'b10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_io_req_arbiter

`default_nettype wire

// File: doc/io_req_arbiter.md
Name: io_req_arbiter

Overview:
- Shares the basic computer's single input register (INPR/FGI) and interrupt line between several byte-wide input requesters: channel 0 is the keyboard (ui_in), channel 1 is the SPI receive byte.
- Each channel has its own holding register, so a strobe is captured even while another channel owns the CPU.
- Pending channels are granted round-robin. The granted byte is held until the CPU executes INP.
- Also owns the output flag FGO, the display latch, and the IEN gating of the CPU interrupt request.

Parameters:
- N_CH, 2, number of input requesters (2..4).
- DW, 8, data width of each channel and of INPR/OUTR.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ch_req  in  N_CH  per-channel request level; rising edge = new byte available.
- ch_data  in  N_CH*DW  per-channel byte; channel i occupies bits [i*DW +: DW].
- ch_ovf  out  N_CH  sticky overrun flag per channel.
- inpr  out  DW  byte presented to the CPU.
- fgi  out  1  input flag to the CPU.
- src  out  2  index of the channel currently granted.
- inp_ack  in  1  one-cycle pulse; CPU executed INP (consumed inpr).
- outr_in  in  DW  CPU AC[7:0] for OUT.
- out_stb  in  1  one-cycle pulse; CPU executed OUT.
- fgo  out  1  output flag.
- disp  out  DW  display latch (drives uo_out).
- ion  in  1  one-cycle pulse; CPU ION.
- iof  in  1  one-cycle pulse; CPU IOF.
- irq  out  1  interrupt request to the CPU.

Behaviour:
- Reset values (rst=1 at a rising edge):
  - holding regs 0, pending 0, ch_ovf 0, inpr 0, fgi 0, src 0;
  - round-robin pointer 0, fgo 1, disp 0, ien 0, irq 0;
  - edge-detect history regs 0, so a request already high at reset release counts as one edge;
  - FSM forced to IDLE, including mid-grant; any byte being presented is discarded.
- Edge capture, per channel:
  - req_q <= ch_req; edge = ch_req & ~req_q.
  - On edge with pending[i]=0: hold[i] <= ch_data slice, pending[i] <= 1.
  - On edge with pending[i]=1: hold[i] keeps the old byte and ch_ovf[i] <= 1. ch_ovf clears only on rst.
- FSM states IDLE, PRESENT, RELEASE:
  - IDLE: if any pending, select the first pending channel at or after the pointer, wrapping modulo N_CH. Then inpr <= hold[sel], src <= sel, fgi <= 1, go to PRESENT. Otherwise stay.
  - PRESENT: inpr/src/fgi stay stable. On inp_ack: pending[src] <= 0, fgi <= 0, pointer <= (src+1) mod N_CH, go to RELEASE.
  - RELEASE: one cycle with fgi=0, then go to IDLE. This guarantees the CPU sees FGI drop between bytes.
  - inp_ack outside PRESENT is ignored.
- Latency: ch_req rises before edge n → pending at n+1 → fgi=1 with valid inpr at n+2. Back-to-back grants are 3 cycles apart after inp_ack (RELEASE, IDLE, PRESENT).
- Simultaneous events:
  - An edge on the granted channel in the same cycle as inp_ack is accepted as a new capture: pending stays 1, hold updates, no overrun.
  - An edge on channel i in the cycle IDLE selects i uses the already-captured byte; the new edge counts as an overrun.
- Output path:
  - out_stb: disp <= outr_in, fgo <= 0.
  - The next cycle, fgo <= 1; the display device is modelled as always ready in one cycle.
  - out_stb while fgo=0 still updates disp.
- Interrupt:
  - ion sets ien, iof clears it; iof wins if both pulse in the same cycle.
  - irq registered: irq <= ien & (fgi | fgo).
  - The CPU clears ien itself on interrupt entry via iof.
- Width rules: pointer and src are 2 bits; wrap is computed modulo N_CH, not modulo 4.

Decomposition:
- Shared package io_pkg holds:
  - FSM state encoding (IDLE=2'd0, PRESENT=2'd1, RELEASE=2'd2);
  - DW default;
  - channel index constants CH_KBD=0, CH_SPI=1.
- One natural sub-module, rr_pick: combinational round-robin selector. Inputs: pending vector, pointer. Outputs: grant index and any-pending. Instantiated once.

Test Plan:
- Reset, then ch_req[0] rising with ch_data byte 0x77 → fgi=1, inpr=0x77, src=0 two cycles after the edge. inp_ack → fgi=0 for exactly 1 cycle, then stays 0.
- Same cycle, ch0=0x77 and ch1=0x66 → first grant ch0/0x77. After inp_ack, grant ch1/0x66 three cycles later, pointer=0. Repeat with ch0=0x11 and ch1=0x22 → ch0 granted first again.
- ch0 edge with 0x77, a second ch0 edge with 0x66 before ack → ch_ovf[0]=1, inpr stays 0x77. After ack, fgi stays low because pending was cleared.
- ion pulse, then ch1 edge with 0x5A → irq=1 one cycle after fgi rises. iof and ion in the same cycle → ien=0, irq=0 next cycle.
- out_stb with outr_in=0x3C → disp=0x3C and fgo=0 the next cycle, fgo=1 the cycle after.
- rst asserted while in PRESENT with 0x77 → next cycle fgi=0, inpr=0, pending=0, fgo=1. The held ch_req counts as a new edge after reset release and is re-captured.
